volume_level_meter: RTL and testbench
=====================================

Name: volume_level_meter

Overview:
- Upstream producer of the 4-bit volume levels consumed by the seven-segment sound display and LED volume bar.
- Takes 12-bit microphone samples (quiescent midpoint ~2048) and tracks the maximum positive excursion over a fixed window of samples.
- At each window end, quantises that maximum into a 0..15 level (volume_raw) and maintains a peak-hold level (volume_peak).

Parameters:
- WINDOW_SAMPLES, 4000: number of accepted samples per measurement window (>=2).
- DECAY_WINDOWS, 4: consecutive non-refreshing windows before volume_peak decays by 1 (>=1).
- MIDPOINT, 2048: mic code treated as silence.
- LEVEL_SHIFT, 7: right shift from amplitude (0..2047) to level (0..15).

Ports:
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; mic_in is sampled only when high.
- mic_in  input  12  unsigned mic sample.
- volume_raw  output  4  level of the most recently completed window.
- volume_peak  output  4  peak-hold level.
- level_valid  output  1  one-cycle pulse when volume_raw and volume_peak update.
- clip  output  1  high for the window in which any sample reached 4095. Updated together with volume_raw.

Behaviour:
- Reset is synchronous and active-high, and has priority over every other input.
  - On reset: volume_raw=0, volume_peak=0, level_valid=0, clip=0, sample counter=0, running max=0, decay counter=0, clip accumulator=0.
  - Reset mid-window discards the partial window.
- Amplitude:
  - amp = mic_in - MIDPOINT when mic_in > MIDPOINT, else 0.
  - Width is 11 bits; any result above 2047 saturates to 2047.
- Accepted sample (sample_valid=1):
  - running_max <= max(running_max, amp).
  - clip_acc <= clip_acc | (mic_in==4095).
  - Sample counter increments.
- Cycles with sample_valid=0: no state change except level_valid returning to 0.
- Window end = accepted sample while counter == WINDOW_SAMPLES-1. In the same clock edge:
  - final = max(running_max, amp of this sample).
  - volume_raw <= final >> LEVEL_SHIFT, truncated to 4 bits.
  - clip <= clip_acc | (this sample==4095).
  - level_valid <= 1 for exactly one cycle, so outputs are visible the cycle after the final sample.
  - running_max <= 0, clip_acc <= 0, counter <= 0 (wrap-around).
- Peak hold, evaluated at window end with new_level = the value just computed for volume_raw:
  - If new_level >= volume_peak: volume_peak <= new_level and decay_cnt <= 0.
  - Otherwise, if decay_cnt == DECAY_WINDOWS-1: volume_peak <= volume_peak-1 and decay_cnt <= 0. Since new_level < volume_peak, there is no underflow.
  - Otherwise: decay_cnt <= decay_cnt+1.
- Between window ends, volume_raw, volume_peak and clip are stable.
- sample_valid on consecutive cycles is legal; the block accepts one sample per clock at full rate.

Optional Feature:
- Macro: VOLUME_PEAK_DECAY_EN.
- Defined: volume_peak decays as described in Behaviour.
- Undefined:
  - No decay counter is built.
  - volume_peak <= max(volume_peak, new_level) at each window end and only returns to 0 on reset.
  - All other behaviour is unchanged.

Test Plan (bench uses WINDOW_SAMPLES=4, DECAY_WINDOWS=2, VOLUME_PEAK_DECAY_EN defined unless stated):
- Reset, then feed 4 samples of 2048 -> level_valid pulses 1 cycle after 4th sample; volume_raw=0, volume_peak=0, clip=0.
- Window {2100, 3000, 2500, 1000} -> amp max 952, volume_raw=7, volume_peak=7. Next window all 2048 -> volume_raw=0, peak stays 7. Next window all 2048 -> peak=6.
- Window containing 4095 -> volume_raw=15, clip=1, peak=15. Next window max 2300 -> raw=1, clip=0, peak=15.
- Assert reset after 2 samples of 4000 -> outputs 0. Next 4 samples of 2048 -> raw=0, proving the partial window was discarded.
- sample_valid gaps of 0, 1 and 7 idle cycles between samples -> level_valid fires only after the 4th accepted sample, and outputs hold between windows.
- VOLUME_PEAK_DECAY_EN undefined: window at level 9 followed by 5 silent windows -> volume_peak stays 9, volume_raw=0.

Source files
------------

// File: rtl/volume_level_meter.sv
// volume_level_meter
// Turns a stream of 12-bit microphone samples into a 0..15 loudness level.
// Over each window of WINDOW_SAMPLES accepted samples it tracks the largest
// excursion above MIDPOINT. At the window end that maximum is quantised into
// volume_raw, and volume_peak (a peak-hold of volume_raw) is updated.
//
// Build option: VOLUME_PEAK_DECAY_EN
//   defined   - volume_peak drops by 1 after DECAY_WINDOWS consecutive
//               windows that do not refresh it.
//   undefined - volume_peak only ever rises; it returns to 0 only on reset.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous active-high reset
//   sample_valid  one-cycle strobe qualifying mic_in
//   mic_in        unsigned 12-bit mic sample
//   volume_raw    level of the most recently completed window
//   volume_peak   peak-hold level
//   level_valid   one-cycle pulse when volume_raw / volume_peak update
//   clip          a sample in the last completed window reached 4095

module volume_level_meter #(
    parameter int WINDOW_SAMPLES = 4000,
    parameter int DECAY_WINDOWS  = 4,
    parameter int MIDPOINT       = 2048,
    parameter int LEVEL_SHIFT    = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [3:0]  volume_raw,
    output logic [3:0]  volume_peak,
    output logic        level_valid,
    output logic        clip
);

    localparam int          CNT_W    = $clog2(WINDOW_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [12:0] MID13    = 13'(MIDPOINT);

    if (WINDOW_SAMPLES < 2 || DECAY_WINDOWS < 1) begin : g_param_check
        $error("volume_level_meter: WINDOW_SAMPLES must be >= 2 and DECAY_WINDOWS >= 1");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      run_max_q, run_max_d;
    logic             clip_acc_q, clip_acc_d;
    logic [3:0]       raw_q, raw_d;
    logic [3:0]       peak_q, peak_d;
    logic             lv_q, lv_d;
    logic             clip_q, clip_d;

`ifdef VOLUME_PEAK_DECAY_EN
    localparam int              DEC_W    = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_WINDOWS - 1);
    logic [DEC_W-1:0] decay_q, decay_d;
`endif

    logic [12:0] diff;
    logic [10:0] amp;
    logic [10:0] sample_max;
    logic [3:0]  new_level;
    logic        is_full;
    logic        win_end;

    always_comb begin
        // Amplitude above the quiescent midpoint, saturated to 11 bits.
        diff = {1'b0, mic_in} - MID13;
        amp  = '0;
        if ({1'b0, mic_in} > MID13) begin
            amp = (diff > 13'd2047) ? 11'h7FF : diff[10:0];
        end
        sample_max = (amp > run_max_q) ? amp : run_max_q;
        new_level  = 4'(sample_max >> LEVEL_SHIFT);
        is_full    = (mic_in == 12'hFFF);
        win_end    = sample_valid && (cnt_q == CNT_LAST);
    end

    always_comb begin
        cnt_d      = cnt_q;
        run_max_d  = run_max_q;
        clip_acc_d = clip_acc_q;
        raw_d      = raw_q;
        peak_d     = peak_q;
        lv_d       = 1'b0;
        clip_d     = clip_q;
`ifdef VOLUME_PEAK_DECAY_EN
        decay_d    = decay_q;
`endif
        if (win_end) begin
            raw_d      = new_level;
            clip_d     = clip_acc_q | is_full;
            lv_d       = 1'b1;
            run_max_d  = '0;
            clip_acc_d = 1'b0;
            cnt_d      = '0;
`ifdef VOLUME_PEAK_DECAY_EN
            if (new_level >= peak_q) begin
                peak_d  = new_level;
                decay_d = '0;
            end else if (decay_q == DEC_LAST) begin
                // new_level < peak_q here, so peak_q is at least 1.
                peak_d  = peak_q - 4'd1;
                decay_d = '0;
            end else begin
                decay_d = decay_q + DEC_W'(1);
            end
`else
            if (new_level > peak_q) begin
                peak_d = new_level;
            end
`endif
        end else if (sample_valid) begin
            run_max_d  = sample_max;
            clip_acc_d = clip_acc_q | is_full;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            run_max_q  <= '0;
            clip_acc_q <= 1'b0;
            raw_q      <= '0;
            peak_q     <= '0;
            lv_q       <= 1'b0;
            clip_q     <= 1'b0;
`ifdef VOLUME_PEAK_DECAY_EN
            decay_q    <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            run_max_q  <= run_max_d;
            clip_acc_q <= clip_acc_d;
            raw_q      <= raw_d;
            peak_q     <= peak_d;
            lv_q       <= lv_d;
            clip_q     <= clip_d;
`ifdef VOLUME_PEAK_DECAY_EN
            decay_q    <= decay_d;
`endif
        end
    end

    assign volume_raw  = raw_q;
    assign volume_peak = peak_q;
    assign level_valid = lv_q;
    assign clip        = clip_q;

endmodule

// File: tb/tb_volume_level_meter.sv
module tb_volume_level_meter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = 12'd2048;
    logic [3:0]  volume_raw;
    logic [3:0]  volume_peak;
    logic        level_valid;
    logic        clip;

    int n_assert = 0;
    int n_fail   = 0;
    int lv_pulses = 0;
    int lv_mark;

    always #5 clk = ~clk;

    volume_level_meter #(
        .WINDOW_SAMPLES(4),
        .DECAY_WINDOWS (2),
        .MIDPOINT      (2048),
        .LEVEL_SHIFT   (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .mic_in      (mic_in),
        .volume_raw  (volume_raw),
        .volume_peak (volume_peak),
        .level_valid (level_valid),
        .clip        (clip)
    );

    always @(posedge clk) if (level_valid) lv_pulses++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int raw, input int peak,
                           input int clp, input int lv);
        chk({tag, ".raw"},  int'(volume_raw),  raw);
        chk({tag, ".peak"}, int'(volume_peak), peak);
        chk({tag, ".clip"}, int'(clip),        clp);
        chk({tag, ".lv"},   int'(level_valid), lv);
    endtask

    // Presents one sample for one clock, then samples outputs 1 ns after the edge.
    task automatic send(input logic [11:0] v);
        sample_valid = 1'b1;
        mic_in = v;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        mic_in = 12'd2048;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic window4(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    int exp_decay_peak [5];

    initial begin
`ifdef VOLUME_PEAK_DECAY_EN
        exp_decay_peak = '{9, 8, 8, 7, 7};
`else
        exp_decay_peak = '{9, 9, 9, 9, 9};
`endif
        // Reset state
        idle(2);
        reset = 1'b0;
        chk_out("reset", 0, 0, 0, 0);

        // Silent window: pulse only after the 4th sample
        send(12'd2048); send(12'd2048); send(12'd2048);
        chk("silent.lv_early", int'(level_valid), 0);
        send(12'd2048);
        chk_out("silent", 0, 0, 0, 1);
        idle(1);
        chk("silent.lv_drop", int'(level_valid), 0);

        // amp max 952 -> 952>>7 = 7
        window4(12'd2100, 12'd3000, 12'd2500, 12'd1000);
        chk_out("w952", 7, 7, 0, 1);

        window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        chk_out("hold1", 0, 7, 0, 1);
        window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
`ifdef VOLUME_PEAK_DECAY_EN
        chk_out("decay1", 0, 6, 0, 1);
`else
        chk_out("decay1", 0, 7, 0, 1);
`endif

        // Full-scale sample: amp saturates at 2047 -> 15, clip set
        window4(12'd2048, 12'd4095, 12'd2048, 12'd2048);
        chk_out("clip", 15, 15, 1, 1);
        // amp max 252 -> 1, clip clears
        window4(12'd2300, 12'd2048, 12'd2000, 12'd2100);
        chk_out("after_clip", 1, 15, 0, 1);
        idle(5);
        chk_out("stable", 1, 15, 0, 0);

        // Reset mid-window discards the partial window
        send(12'd4000); send(12'd4000);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk_out("midreset", 0, 0, 0, 0);
        send(12'd2048); send(12'd2048); send(12'd2048);
        chk("midreset.lv_early", int'(level_valid), 0);
        send(12'd2048);
        chk_out("post_reset", 0, 0, 0, 1);

        // Gaps of 0, 1 and 7 idle cycles; amp 552 -> 4
        idle(1);
        lv_mark = lv_pulses;
        send(12'd2600);
        send(12'd2048);
        idle(1);
        send(12'd2048);
        idle(7);
        chk("gap.no_pulse", lv_pulses - lv_mark, 0);
        chk_out("gap.hold", 0, 0, 0, 0);
        send(12'd2048);
        chk_out("gap", 4, 4, 0, 1);
        idle(3);
        chk("gap.one_pulse", lv_pulses - lv_mark, 1);
        chk_out("gap.after", 4, 4, 0, 0);

        // Level 9 (amp 1200) then 5 silent windows
        window4(12'd3248, 12'd2048, 12'd2048, 12'd2048);
        chk_out("lvl9", 9, 9, 0, 1);
        for (int w = 0; w < 5; w++) begin
            window4(12'd2048, 12'd2048, 12'd2048, 12'd2048);
            chk($sformatf("quiet%0d.peak", w), int'(volume_peak), exp_decay_peak[w]);
            chk($sformatf("quiet%0d.raw", w), int'(volume_raw), 0);
        end

        // Level boundary: amp 127 -> 0, amp 128 -> 1
        window4(12'd2175, 12'd2048, 12'd2048, 12'd2048);
        chk("amp127.raw", int'(volume_raw), 0);
        window4(12'd2048, 12'd2048, 12'd2048, 12'd2176);
        chk("amp128.raw", int'(volume_raw), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
